// File: rtl/alu_issue_stage.sv
// Issue/writeback stage for RV32E OP and OP-IMM instructions in front of a combinational ALU.
// Owns the 16x32 register file and retires one instruction every three cycles.
module alu_issue_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] alu_value1,
    output logic [XLEN-1:0] alu_value2,
    output logic [2:0]      alu_func_type,
    output logic            alu_f7_bit,
    input  logic [XLEN-1:0] alu_result,
    output logic            done,
    output logic            illegal,
    input  logic [3:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC
    } state_t;

    state_t          state;
    logic [XLEN-1:0] regs [NUM_REGS];

    logic [3:0]      rs1_q;
    logic [3:0]      rd_q;
    logic [2:0]      funct3_q;
    logic [11:0]     imm_q;
    logic            is_op_q;

    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic            is_shift;
    logic            instr_legal;

    always_comb begin
        opcode      = instr[6:0];
        funct3      = instr[14:12];
        funct7      = instr[31:25];
        is_shift    = (funct3 == 3'b001) || (funct3 == 3'b101);
        instr_legal = 1'b0;
        if (!instr[19] && !instr[11]) begin
            if (opcode == OPC_OP)
                instr_legal = !instr[24] &&
                              ((funct7 == 7'h00) ||
                               ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            else if (opcode == OPC_IMM)
                instr_legal = !is_shift || (funct7 == 7'h00) ||
                              ((funct7 == 7'h20) && (funct3 == 3'b101));
        end
    end

    // Only the fields needed after acceptance are kept; imm_q doubles as rs2/shamt/funct7 for OP.
    logic [XLEN-1:0] operand2;
    logic            f7_next;

    always_comb begin
        if (is_op_q) begin
            operand2 = regs[imm_q[3:0]];
            f7_next  = imm_q[10];
        end else if ((funct3_q == 3'b001) || (funct3_q == 3'b101)) begin
            operand2 = {{(XLEN-5){1'b0}}, imm_q[4:0]};
            f7_next  = imm_q[10];
        end else begin
            operand2 = {{(XLEN-12){imm_q[11]}}, imm_q};
            f7_next  = 1'b0;
        end
    end

    assign instr_ready = (state == IDLE);
    assign dbg_data    = (dbg_addr == 4'd0) ? '0 : regs[dbg_addr];

    // EXEC's closing edge both captures the ALU result and writes rd, so done lands with IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rs1_q         <= '0;
            rd_q          <= '0;
            funct3_q      <= '0;
            imm_q         <= '0;
            is_op_q       <= 1'b0;
            alu_value1    <= '0;
            alu_value2    <= '0;
            alu_func_type <= '0;
            alu_f7_bit    <= 1'b0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (instr_legal) begin
                            rs1_q    <= instr[18:15];
                            rd_q     <= instr[10:7];
                            funct3_q <= instr[14:12];
                            imm_q    <= instr[31:20];
                            is_op_q  <= (instr[6:0] == OPC_OP);
                            state    <= READ;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                READ: begin
                    alu_value1    <= regs[rs1_q];
                    alu_value2    <= operand2;
                    alu_func_type <= funct3_q;
                    alu_f7_bit    <= f7_next;
                    state         <= EXEC;
                end
                EXEC: begin
                    if (rd_q != 4'd0)
                        regs[rd_q] <= alu_result;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, random instructions against an ISA-level
// register model, a reset-abort sequence and a back-to-back valid stream.
`timescale 1ns/1ps
module tb_alu_issue_stage;
    typedef struct {
        logic [31:0] instr;
        logic        illegal;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rd_val;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_value1;
    logic [31:0] alu_value2;
    logic [2:0]  alu_func_type;
    logic        alu_f7_bit;
    logic [31:0] alu_result;
    logic        done;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int          n_cmp;
    int          n_bad;
    logic [31:0] model_regs [16];
    vec_t        tbl [15];

    alu_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .alu_value1    (alu_value1),
        .alu_value2    (alu_value2),
        .alu_func_type (alu_func_type),
        .alu_f7_bit    (alu_f7_bit),
        .alu_result    (alu_result),
        .done          (done),
        .illegal       (illegal),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;

    // RV32 integer ALU semantics; drives the DUT's alu_result and feeds the register model.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic alt);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'd0: begin
                if (alt) return a - b;
                return a + b;
            end
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (alt) return sa >>> b[4:0];
                return a >> b[4:0];
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_value1, alu_value2, alu_func_type, alu_f7_bit);

    function automatic vec_t model_predict(input logic [31:0] ins);
        vec_t        v;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        int          rs1;
        int          rs2;
        int          rd;
        bit          legal;
        logic        alt;
        logic [31:0] a;
        logic [31:0] b;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        rd  = int'(ins[11:7]);
        legal = 1'b0;
        if (opc == 7'b0110011)
            legal = (rs1 < 16) && (rs2 < 16) && (rd < 16) &&
                    ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
        else if (opc == 7'b0010011) begin
            if (f3 == 3'd1)
                legal = (rs1 < 16) && (rd < 16) && (f7 == 7'h00);
            else if (f3 == 3'd5)
                legal = (rs1 < 16) && (rd < 16) && ((f7 == 7'h00) || (f7 == 7'h20));
            else
                legal = (rs1 < 16) && (rd < 16);
        end
        v.instr   = ins;
        v.illegal = !legal;
        v.v1      = '0;
        v.v2      = '0;
        v.f3      = '0;
        v.f7      = 1'b0;
        v.rd_val  = model_regs[rd % 16];
        if (legal) begin
            a = model_regs[rs1];
            if (opc == 7'b0110011) begin
                b   = model_regs[rs2];
                alt = ins[30];
            end else if ((f3 == 3'd1) || (f3 == 3'd5)) begin
                b   = {27'b0, ins[24:20]};
                alt = ins[30];
            end else begin
                b   = {{20{ins[31]}}, ins[31:20]};
                alt = 1'b0;
            end
            v.v1     = a;
            v.v2     = b;
            v.f3     = f3;
            v.f7     = alt;
            v.rd_val = (rd == 0) ? 32'd0 : alu_ref(a, b, f3, alt);
        end
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          sel;
        ins = $urandom();
        sel = $urandom_range(0, 19);
        if (sel < 9)
            ins[6:0] = 7'b0110011;
        else if (sel < 18)
            ins[6:0] = 7'b0010011;
        if ($urandom_range(0, 7) != 0) begin
            ins[19] = 1'b0;
            ins[11] = 1'b0;
        end
        if ((ins[6:0] == 7'b0110011) && ($urandom_range(0, 7) != 0))
            ins[24] = 1'b0;
        case ($urandom_range(0, 4))
            0, 1: ins[31:25] = 7'h00;
            2, 3: ins[31:25] = 7'h20;
            default: ;
        endcase
        return ins;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called on a negedge; returns on the negedge where the stage is ready again.
    task automatic apply_stimulus(input vec_t v, input string tag);
        int waited;
        waited = 0;
        while (!instr_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_output({tag, ".ready_wait"}, 32'(instr_ready), 32'd1);
        if (!instr_ready) return;
        dbg_addr    = v.instr[10:7];
        instr       = v.instr;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = $urandom();
        check_output({tag, ".done_c1"}, 32'(done), 32'd0);
        check_output({tag, ".illegal_c1"}, 32'(illegal), 32'(v.illegal));
        if (v.illegal) begin
            check_output({tag, ".ready_c1"}, 32'(instr_ready), 32'd1);
            @(negedge clk);
            check_output({tag, ".illegal_c2"}, 32'(illegal), 32'd0);
            check_output({tag, ".done_c2"}, 32'(done), 32'd0);
            check_output({tag, ".rd_kept"}, dbg_data, v.rd_val);
            return;
        end
        @(negedge clk);
        check_output({tag, ".done_c2"}, 32'(done), 32'd0);
        check_output({tag, ".value1"}, alu_value1, v.v1);
        check_output({tag, ".value2"}, alu_value2, v.v2);
        check_output({tag, ".func_type"}, 32'(alu_func_type), 32'(v.f3));
        check_output({tag, ".f7_bit"}, 32'(alu_f7_bit), 32'(v.f7));
        @(negedge clk);
        check_output({tag, ".done_c3"}, 32'(done), 32'd1);
        check_output({tag, ".ready_c3"}, 32'(instr_ready), 32'd1);
        check_output({tag, ".rd_value"}, dbg_data, v.rd_val);
        if (v.instr[10:7] != 4'd0)
            model_regs[v.instr[10:7]] = v.rd_val;
    endtask

    // instr_valid stays high throughout; instr is scrambled while the stage is busy.
    task automatic run_back_to_back(input int count);
        vec_t        v;
        vec_t        prev;
        logic [31:0] ins;
        int          tries;
        prev = model_predict(32'h00000013);
        instr_valid = 1'b1;
        for (int cyc = 0; cyc <= 3 * count; cyc++) begin
            check_output($sformatf("b2b%0d.ready", cyc), 32'(instr_ready), 32'((cyc % 3) == 0));
            check_output($sformatf("b2b%0d.done", cyc), 32'(done), 32'(((cyc % 3) == 0) && (cyc > 0)));
            check_output($sformatf("b2b%0d.illegal", cyc), 32'(illegal), 32'd0);
            if ((cyc % 3) == 0) begin
                if (cyc > 0)
                    check_output($sformatf("b2b%0d.rd_value", cyc), dbg_data, prev.rd_val);
                if (cyc < 3 * count) begin
                    ins   = rand_instr();
                    tries = 0;
                    while (model_predict(ins).illegal && tries < 200) begin
                        ins = rand_instr();
                        tries++;
                    end
                    if (model_predict(ins).illegal)
                        ins = 32'h00108133;
                    v        = model_predict(ins);
                    instr    = v.instr;
                    dbg_addr = v.instr[10:7];
                    if (v.instr[10:7] != 4'd0)
                        model_regs[v.instr[10:7]] = v.rd_val;
                    prev = v;
                end else begin
                    instr_valid = 1'b0;
                end
            end else begin
                instr = $urandom();
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int r = 0; r < 16; r++) model_regs[r] = '0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reset.ready", 32'(instr_ready), 32'd1);
        check_output("reset.done", 32'(done), 32'd0);
        check_output("reset.illegal", 32'(illegal), 32'd0);
        check_output("reset.value1", alu_value1, 32'd0);
        check_output("reset.value2", alu_value2, 32'd0);
        check_output("reset.func_type", 32'(alu_func_type), 32'd0);

        // Abort ADDI x1,x0,5 with reset while it sits in EXEC.
        dbg_addr    = 4'd1;
        instr       = 32'h00500093;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check_output("abort.pre_value2", alu_value2, 32'd5);
        rst_n = 1'b0;
        #1;
        check_output("abort.ready", 32'(instr_ready), 32'd1);
        check_output("abort.value1", alu_value1, 32'd0);
        check_output("abort.value2", alu_value2, 32'd0);
        check_output("abort.f7_bit", 32'(alu_f7_bit), 32'd0);
        check_output("abort.done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output($sformatf("abort.no_done%0d", i), 32'(done), 32'd0);
            check_output($sformatf("abort.reg1_%0d", i), dbg_data, 32'd0);
        end
        check_output("abort.ready_after", 32'(instr_ready), 32'd1);

        tbl[0]  = '{32'h00500093, 1'b0, 32'h0,        32'h5,        3'd0, 1'b0, 32'h5};
        tbl[1]  = '{32'h00108133, 1'b0, 32'h5,        32'h5,        3'd0, 1'b0, 32'hA};
        tbl[2]  = '{32'hFFF00193, 1'b0, 32'h0,        32'hFFFFFFFF, 3'd0, 1'b0, 32'hFFFFFFFF};
        tbl[3]  = '{32'h4041D213, 1'b0, 32'hFFFFFFFF, 32'h4,        3'd5, 1'b1, 32'hFFFFFFFF};
        tbl[4]  = '{32'h00700013, 1'b0, 32'h0,        32'h7,        3'd0, 1'b0, 32'h0};
        tbl[5]  = '{32'h01000833, 1'b1, 32'h0,        32'h0,        3'd0, 1'b0, 32'h0};
        tbl[6]  = '{32'h401102B3, 1'b0, 32'hA,        32'h5,        3'd0, 1'b1, 32'h5};
        tbl[7]  = '{32'h00309313, 1'b0, 32'h5,        32'h3,        3'd1, 1'b0, 32'h28};
        tbl[8]  = '{32'h00002083, 1'b1, 32'h0,        32'h0,        3'd0, 1'b0, 32'h5};
        tbl[9]  = '{32'h40109133, 1'b1, 32'h0,        32'h0,        3'd0, 1'b0, 32'hA};
        tbl[10] = '{32'h40309313, 1'b1, 32'h0,        32'h0,        3'd0, 1'b0, 32'h28};
        tbl[11] = '{32'h00180093, 1'b1, 32'h0,        32'h0,        3'd0, 1'b0, 32'h5};
        tbl[12] = '{32'h01000393, 1'b0, 32'h0,        32'h10,       3'd0, 1'b0, 32'h10};
        tbl[13] = '{32'h0241D213, 1'b1, 32'h0,        32'h0,        3'd0, 1'b0, 32'hFFFFFFFF};
        tbl[14] = '{32'h001181B3, 1'b0, 32'hFFFFFFFF, 32'h5,        3'd0, 1'b0, 32'h4};
        for (int i = 0; i < 15; i++)
            apply_stimulus(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++)
            apply_stimulus(model_predict(rand_instr()), $sformatf("rnd%0d", i));

        @(negedge clk);
        run_back_to_back(12);

        for (int r = 0; r < 16; r++) begin
            dbg_addr = 4'(r);
            #1;
            check_output($sformatf("final.x%0d", r), dbg_data, model_regs[r]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
